mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS core's execute stage. It consumes the two operands read from the register file, computes a 2×WORD_SIZE product or a quotient/remainder pair over several cycles, and holds the result in the architectural HI/LO registers. MFHI/MFLO read HI/LO and pass them to writeback. The pipeline stalls on `busy`.

---
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers; WORD_SIZE+1 edges per operation.
// Define MUL_DIV_SIGNED_EN to give MULT/DIV signed semantics; otherwise op[0] is ignored (all unsigned).
module mul_div_unit #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] operand_a,
  input  logic [WORD_SIZE-1:0] operand_b,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo
);
  localparam int W  = WORD_SIZE;
  localparam int W2 = 2 * WORD_SIZE;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return (~x) + W'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] x);
    return (~x) + W2'(1);
  endfunction

  logic signed_op;
`ifdef MUL_DIV_SIGNED_EN
  assign signed_op = op[0];
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign signed_op  = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic [W-1:0]     acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic             sgn_a, sgn_b, div_zero;
  logic [W:0]       rem_sh, sum;
  logic [W-1:0]     diff;

  assign sgn_a    = signed_op & operand_a[W-1];
  assign sgn_b    = signed_op & operand_b[W-1];
  assign div_zero = op[1] && (operand_b == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    rem_sh    = {acc_hi_q, acc_lo_q[W-1]};
    diff      = rem_sh[W-1:0] - opb_q;
    sum       = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = data_in;
        if (lo_we) lo_d = data_in;
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = CNT_W'(W);
          is_div_d = op[1];
          acc_hi_d = '0;
          // Divide by zero runs on the raw dividend so the remainder ends up as operand_a unchanged.
          if (div_zero) begin
            acc_lo_d  = operand_a;
            opb_d     = operand_b;
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            acc_lo_d  = sgn_a ? neg_w(operand_a) : operand_a;
            opb_d     = sgn_b ? neg_w(operand_b) : operand_b;
            neg_res_d = sgn_a ^ sgn_b;
            neg_rem_d = sgn_a & op[1];
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        if (is_div_q) begin
          // Restoring step: the partial remainder is always below the divisor, so diff fits W bits.
          if (rem_sh >= {1'b0, opb_q}) begin
            acc_hi_d = diff;
            acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_sh[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = sum[W:1];
          acc_lo_d = {sum[0], acc_lo_q[W-1:1]};
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_res_q ? neg_w(acc_lo_q) : acc_lo_q;
          hi_d = neg_rem_q ? neg_w(acc_hi_q) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
    opb_q     <= opb_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a latency/arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we), .data_in(data_in),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: plain integer math on the architectural rules.
  function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [63:0] p;
    longint sa, sb;
    bit sgn;
`ifdef MUL_DIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[1]) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, a} * {32'b0, b};
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 0) begin
      rl = '1;
      rh = a;
    end else if (sgn) begin
      rl = 32'(sa / sb);
      rh = 32'(sa % sb);
    end else begin
      rl = a / b;
      rh = a % b;
    end
  endfunction

  // Cycle model: an accepted start lands its result W+1 edges later; MT writes only when idle.
  int           m_left = 0;
  bit           m_init = 0;
  bit           m_done = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 0; m_init = 1;
    end else begin
      m_done = 0;
      if (m_left == 0) begin
        if (hi_we) m_hi = data_in;
        if (lo_we) m_lo = data_in;
        if (start) begin
          ref_op(op, operand_a, operand_b, p_hi, p_lo);
          m_left = W + 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("busy", W'(busy), W'(m_left != 0));
        chk("done", W'(done), W'(m_done));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
      end
    end
  endtask

  task automatic issue_now(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    issue_now(o, a, b);
  endtask

  // Returns at the negedge where done is seen; steps = negedges advanced, bcnt = busy cycles seen.
  task automatic wait_done(input string name, output int steps, output int bcnt);
    bit ok;
    ok = 0; steps = 0; bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      steps++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: done not seen within 100 cycles", name);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    int steps, bcnt, dcnt;
    fork compare_loop(); join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", steps, bcnt);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    chk("multu_latency", W'(steps), W'(W + 1));
    chk("multu_busy_cycles", W'(bcnt), W'(W + 1));
    @(negedge clk);
    chk("done_one_cycle", W'(done), '0);

`ifdef MUL_DIV_SIGNED_EN
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", steps, bcnt);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", steps, bcnt);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", steps, bcnt);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);
`else
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_uns", steps, bcnt);
    chk("mult_uns_hi", hi, 32'h0000_0006);
    chk("mult_uns_lo", lo, 32'hFFFF_FFEB);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_uns", steps, bcnt);
    chk("div_uns_lo", lo, 32'h7FFF_FFFC);
    chk("div_uns_hi", hi, 32'h0000_0001);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", steps, bcnt);
    chk("div_ovf_lo", lo, 32'h0000_0000);
    chk("div_ovf_hi", hi, 32'h8000_0000);
`endif

    issue(2'b10, 32'd100, 32'd0);
    wait_done("divu_zero", steps, bcnt);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'd100);
    chk("divu_zero_latency", W'(steps), W'(W + 1));

    // Back-to-back start in the done cycle, plus an ignored start mid-run.
    issue_now(2'b10, 32'd10, 32'd3);
    repeat (4) @(negedge clk);
    issue_now(2'b00, 32'd5, 32'd5);
    wait_done("b2b", steps, bcnt);
    chk("b2b_latency", W'(steps + 5), W'(W + 1));
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd3);
    repeat (3) @(negedge clk);
    chk("midrun_start_ignored", W'(busy), '0);

    hi_we = 1'b1; data_in = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    lo_we = 1'b1; data_in = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h5678);
    issue(2'b00, 32'd2, 32'd3);
    hi_we = 1'b1; lo_we = 1'b1; data_in = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_busy", hi, 32'h1234);
    chk("mtlo_busy", lo, 32'h5678);
    wait_done("mt_mul", steps, bcnt);
    chk("mt_mul_lo", lo, 32'd6);

    hi_we = 1'b1; data_in = 32'hAAAA;
    issue_now(2'b00, 32'd4, 32'd5);
    hi_we = 1'b0;
    chk("mthi_with_start", hi, 32'hAAAA);
    wait_done("mt_start", steps, bcnt);
    chk("mt_start_hi", hi, 32'd0);
    chk("mt_start_lo", lo, 32'd20);

    issue(2'b01, 32'h0001_2345, 32'h0000_0777);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", W'(busy), '0);
    chk("rst_mid_hi", hi, '0);
    chk("rst_mid_lo", lo, '0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("rst_no_done", W'(dcnt), '0);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 5) == 0);
      op        = 2'($urandom_range(0, 3));
      operand_a = pick();
      operand_b = pick();
      hi_we     = ($urandom_range(0, 9) == 0);
      lo_we     = ($urandom_range(0, 9) == 0);
      data_in   = W'($urandom());
      rst       = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rst = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
